// File: rtl/gba_ds_fifo_if.sv
// Bundle of IO-bus push signals and direct_sound consumer signals for one Direct Sound FIFO.
// Status outputs exist only when GBA_DS_FIFO_STATUS_EN is defined.
interface gba_ds_fifo_if;
    logic [11:0] io_addr;
    logic        io_write;
    logic [31:0] bus_wdata;
    logic        FIFO_re;
    logic        FIFO_clr;
    logic [31:0] FIFO_val;
    logic [3:0]  FIFO_size;
    logic        fifo_low;
    logic        fifo_full;
`ifdef GBA_DS_FIFO_STATUS_EN
    logic        fifo_ovf;
    logic        fifo_unf;
    logic [7:0]  ovf_count;

    modport master (
        output io_addr, io_write, bus_wdata, FIFO_re, FIFO_clr,
        input  FIFO_val, FIFO_size, fifo_low, fifo_full, fifo_ovf, fifo_unf, ovf_count
    );
    modport slave (
        input  io_addr, io_write, bus_wdata, FIFO_re, FIFO_clr,
        output FIFO_val, FIFO_size, fifo_low, fifo_full, fifo_ovf, fifo_unf, ovf_count
    );
`else
    modport master (
        output io_addr, io_write, bus_wdata, FIFO_re, FIFO_clr,
        input  FIFO_val, FIFO_size, fifo_low, fifo_full
    );
    modport slave (
        input  io_addr, io_write, bus_wdata, FIFO_re, FIFO_clr,
        output FIFO_val, FIFO_size, fifo_low, fifo_full
    );
`endif
endinterface

// File: rtl/gba_ds_fifo.sv
// Eight-word show-ahead sample FIFO for one GBA Direct Sound channel.
// Optional sticky overflow/underflow status is enabled by defining GBA_DS_FIFO_STATUS_EN.
module gba_ds_fifo #(
    parameter logic [11:0] FIFO_ADDR = 12'h0A0,
    parameter int          DEPTH     = 8
) (
    input logic           gba_clk,
    input logic           reset,
    gba_ds_fifo_if.slave  bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LOW_CNT  = (AW+1)'(DEPTH / 2);

    logic [31:0]   r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_empty;
    logic [AW-1:0] w_wr_idx;
    logic          w_unused;

    assign w_unused   = &{1'b0, bus.io_addr[1:0]};
    assign w_empty    = (r_count == '0);
    assign w_push_req = bus.io_write && (bus.io_addr[11:2] == FIFO_ADDR[11:2]);
    // A clear discards any pop; a pop in the same cycle frees a slot for a push at full.
    assign w_pop      = bus.FIFO_re && !w_empty && !bus.FIFO_clr;
    assign w_push     = w_push_req && (bus.FIFO_clr || (r_count != FULL_CNT) || w_pop);
    assign w_wr_idx   = bus.FIFO_clr ? '0 : r_wr_ptr;

    always_ff @(posedge gba_clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.FIFO_clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push ? AW'(1) : '0;
            r_count  <= w_push ? (AW+1)'(1) : '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
        end
    end

    // Sample storage is never cleared; only the pointers and count define validity.
    always_ff @(posedge gba_clk) begin
        if (reset && w_push) r_mem[w_wr_idx] <= bus.bus_wdata;
    end

    assign bus.FIFO_val  = w_empty ? 32'h0 : r_mem[r_rd_ptr];
    assign bus.FIFO_size = 4'(r_count);
    assign bus.fifo_low  = (r_count <= LOW_CNT);
    assign bus.fifo_full = (r_count == FULL_CNT);

`ifdef GBA_DS_FIFO_STATUS_EN
    logic       r_ovf;
    logic       r_unf;
    logic [7:0] r_ovf_count;
    logic       w_drop;
    logic       w_unf;

    assign w_drop = w_push_req && !w_push;
    // A pop against an empty FIFO is not an underflow when a push lands in the same cycle.
    assign w_unf  = bus.FIFO_re && w_empty && !w_push_req;

    always_ff @(posedge gba_clk) begin
        if (!reset || bus.FIFO_clr) begin
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_ovf_count <= 8'h00;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            if (w_unf)  r_unf <= 1'b1;
            if (w_drop && (r_ovf_count != 8'hFF)) r_ovf_count <= r_ovf_count + 8'h01;
        end
    end

    assign bus.fifo_ovf  = r_ovf;
    assign bus.fifo_unf  = r_unf;
    assign bus.ovf_count = r_ovf_count;
`endif
endmodule

// File: tb/tb_gba_ds_fifo.sv
// Bench for gba_ds_fifo: queue-based reference model compared every cycle, plus directed literal checks.
module tb_gba_ds_fifo;
    localparam logic [11:0] ADDR = 12'h0A0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;
    bit   chk_en = 1'b0;

    gba_ds_fifo_if bif();

    gba_ds_fifo #(.FIFO_ADDR(ADDR), .DEPTH(8)) dut (
        .gba_clk (clk),
        .reset   (rst_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue of words plus sticky status.
    logic [31:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    int          m_ovf_cnt = 0;

    always @(posedge clk) begin
        bit push;
        push = bif.io_write && (bif.io_addr[11:2] == ADDR[11:2]);
        if (!rst_n) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_ovf_cnt = 0;
        end else if (bif.FIFO_clr) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_ovf_cnt = 0;
            if (push) q.push_back(bif.bus_wdata);
        end else begin
            if (bif.FIFO_re) begin
                if (q.size() > 0) void'(q.pop_front());
                else if (!push) m_unf = 1;
            end
            if (push) begin
                if (q.size() < 8) q.push_back(bif.bus_wdata);
                else begin
                    m_ovf = 1;
                    if (m_ovf_cnt < 255) m_ovf_cnt++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_size", 32'(bif.FIFO_size), 32'(q.size()));
            chk("model_val", bif.FIFO_val, (q.size() == 0) ? 32'h0 : q[0]);
            chk("model_low", 32'(bif.fifo_low), 32'(q.size() <= 4));
            chk("model_full", 32'(bif.fifo_full), 32'(q.size() == 8));
`ifdef GBA_DS_FIFO_STATUS_EN
            chk("model_ovf", 32'(bif.fifo_ovf), 32'(m_ovf));
            chk("model_unf", 32'(bif.fifo_unf), 32'(m_unf));
            chk("model_ovf_count", 32'(bif.ovf_count), 32'(m_ovf_cnt));
`endif
        end
    end

    task automatic cyc(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input bit re, input bit clr);
        bif.io_write  = wr;
        bif.io_addr   = a;
        bif.bus_wdata = d;
        bif.FIFO_re   = re;
        bif.FIFO_clr  = clr;
        @(posedge clk);
        #1;
        bif.io_write = 1'b0;
        bif.FIFO_re  = 1'b0;
        bif.FIFO_clr = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        cyc(1'b1, ADDR, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, ADDR, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        bif.io_addr   = ADDR;
        bif.io_write  = 1'b1;
        bif.bus_wdata = 32'h12345678;
        bif.FIFO_re   = 1'b0;
        bif.FIFO_clr  = 1'b0;

        // Reset held two cycles with a push pending.
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bif.io_write = 1'b0;
        chk("reset_size", 32'(bif.FIFO_size), 32'd0);
        chk("reset_val", bif.FIFO_val, 32'h0);
        chk("reset_low", 32'(bif.fifo_low), 32'd1);
        chk("reset_full", 32'(bif.fifo_full), 32'd0);

        // Fill, then overflow.
        for (int k = 1; k <= 8; k++) push(32'h11111111 * k);
        chk("fill_size", 32'(bif.FIFO_size), 32'd8);
        chk("fill_full", 32'(bif.fifo_full), 32'd1);
        push(32'hDEADBEEF);
        chk("ovf_size", 32'(bif.FIFO_size), 32'd8);
`ifdef GBA_DS_FIFO_STATUS_EN
        chk("ovf_count_lit", 32'(bif.ovf_count), 32'd1);
`endif
        // Drain.
        for (int k = 1; k <= 8; k++) begin
            chk("drain_val", bif.FIFO_val, 32'h11111111 * k);
            pop();
            chk("drain_low", 32'(bif.fifo_low), 32'(k >= 4));
        end
        chk("drain_val_empty", bif.FIFO_val, 32'h0);

        // Wrap: push 5 / pop 5 / push 8 / pop 8.
        for (int k = 0; k < 5; k++) push(32'hA0000000 + k);
        for (int k = 0; k < 5; k++) begin
            chk("wrap_a_val", bif.FIFO_val, 32'hA0000000 + k);
            pop();
        end
        for (int k = 0; k < 8; k++) push(32'hB0000000 + k);
        chk("wrap_full", 32'(bif.fifo_full), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("wrap_b_val", bif.FIFO_val, 32'hB0000000 + k);
            pop();
        end
        chk("wrap_size", 32'(bif.FIFO_size), 32'd0);

        // Simultaneous push+pop at full.
        for (int k = 0; k < 8; k++) push(32'hC0000000 + k);
        cyc(1'b1, ADDR, 32'hD00DD00D, 1'b1, 1'b0);
        chk("pp_full_size", 32'(bif.FIFO_size), 32'd8);
        for (int k = 1; k < 8; k++) pop();
        chk("pp_full_newword", bif.FIFO_val, 32'hD00DD00D);
        pop();

        // Simultaneous push+pop at empty.
        cyc(1'b1, ADDR, 32'hE1E2E3E4, 1'b1, 1'b0);
        chk("pp_empty_size", 32'(bif.FIFO_size), 32'd1);
        chk("pp_empty_val", bif.FIFO_val, 32'hE1E2E3E4);
`ifdef GBA_DS_FIFO_STATUS_EN
        chk("pp_empty_unf", 32'(bif.fifo_unf), 32'd0);
`endif
        pop();
        pop();  // pop while empty: state unchanged

        // Clear with simultaneous push at size 6.
        for (int k = 0; k < 6; k++) push(32'hF0000000 + k);
        cyc(1'b1, ADDR, 32'hCAFEF00D, 1'b1, 1'b1);
        chk("clr_size", 32'(bif.FIFO_size), 32'd1);
        chk("clr_val", bif.FIFO_val, 32'hCAFEF00D);
`ifdef GBA_DS_FIFO_STATUS_EN
        chk("clr_ovf", 32'(bif.fifo_ovf), 32'd0);
        chk("clr_unf", 32'(bif.fifo_unf), 32'd0);
`endif

        // Address decode: byte offset 2 hits, next word misses.
        cyc(1'b0, ADDR, 32'h0, 1'b0, 1'b1);
        v = 32'h00000001;
        cyc(1'b1, ADDR + 12'd2, v, 1'b0, 1'b0);
        cyc(1'b1, ADDR + 12'd4, 32'h00000002, 1'b0, 1'b0);
        chk("dec_size", 32'(bif.FIFO_size), 32'd1);
        chk("dec_val", bif.FIFO_val, v);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
